// File: rtl/sixteen_bit_sub_seq_if.sv
// Operand/result handshake bundle for the slice-serial subtractor.
// The producer/consumer side uses master; the subtractor uses slave.
interface sixteen_bit_sub_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, d, bout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, d, bout, ovf, zero
  );
endinterface

// File: rtl/sixteen_bit_sub_seq.sv
// Slice-serial subtractor: d = a - b - bin, one SLICE-bit chunk per clock,
// LSB first, with the borrow carried between slices in a register.
module sixteen_bit_sub_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  sixteen_bit_sub_seq_if.slave bus
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int MSB    = WIDTH - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  generate
    if ((SLICE <= 0) || ((WIDTH % SLICE) != 0)) begin : g_bad_slice
      $fatal(1, "sixteen_bit_sub_seq: WIDTH must be a positive multiple of SLICE");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   d_q;
  logic               brw_q;
  logic [IDX_W-1:0]   idx_q;
  logic               bout_q;
  logic               ovf_q;
  logic               zero_q;

  logic [SLICE:0]     slice_d;
  logic [WIDTH-1:0]   d_d;

  // One slice of x - y - bw; the extra top bit is the borrow out.
  function automatic logic [SLICE:0] sub_slice(input logic [SLICE-1:0] x,
                                               input logic [SLICE-1:0] y,
                                               input logic             bw);
    return {1'b0, x} - {1'b0, y} - {{SLICE{1'b0}}, bw};
  endfunction

  always_comb begin
    slice_d = sub_slice(a_q[idx_q*SLICE +: SLICE], b_q[idx_q*SLICE +: SLICE], brw_q);
    d_d     = d_q;
    d_d[idx_q*SLICE +: SLICE] = slice_d[SLICE-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      brw_q   <= 1'b0;
      idx_q   <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            brw_q   <= bus.bin;
            idx_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          d_q   <= d_d;
          brw_q <= slice_d[SLICE];
          idx_q <= idx_q + 1'b1;
          // Flags are settled from the fully assembled difference on the last slice.
          if (idx_q == LAST_IDX) begin
            state_q <= DONE;
            bout_q  <= slice_d[SLICE];
            ovf_q   <= (a_q[MSB] != b_q[MSB]) && (d_d[MSB] != a_q[MSB]);
            zero_q  <= (d_d == '0);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.d         = d_q;
  assign bus.bout      = bout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_sixteen_bit_sub_seq.sv
// Scoreboard bench for sixteen_bit_sub_seq: driver pushes reference results,
// a negedge monitor pops and compares each accepted output.
module tb_sixteen_bit_sub_seq;

  typedef struct {
    logic [15:0] d;
    logic        bout;
    logic        ovf;
    logic        zero;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;
  exp_t sb_q[$];

  sixteen_bit_sub_seq_if #(.WIDTH(16)) bus ();

  sixteen_bit_sub_seq #(.WIDTH(16), .SLICE(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model from plain integer arithmetic.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic bin);
    exp_t e;
    int ua, ub, sa, sb, ib, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    ib = bin ? 1 : 0;
    sr = sa - sb - ib;
    e.d    = 16'((ua - ub - ib) & 32'hFFFF);
    e.bout = (ua < ub + ib);
    e.ovf  = (sr < -32768) || (sr > 32767);
    e.zero = (e.d == 16'h0);
    return e;
  endfunction

  // Monitor: a result is consumed on the edge following a negedge with valid&ready.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_result: got d=%h with empty scoreboard", bus.d);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_d",    32'(bus.d),    32'(e.d));
        chk("sb_bout", 32'(bus.bout), 32'(e.bout));
        chk("sb_ovf",  32'(bus.ovf),  32'(e.ovf));
        chk("sb_zero", 32'(bus.zero), 32'(e.zero));
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic bin);
    int n;
    bus.a = a; bus.b = b; bus.bin = bin; bus.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_total++;
      $display("FAIL issue_timeout: in_ready stayed %0b required 1", bus.in_ready);
    end
    @(posedge clk);
    sb_q.push_back(model(a, b, bin));
    #1 bus.in_valid = 1'b0;
  endtask

  // Counts rising edges after the accept until out_valid; returns on that negedge.
  task automatic wait_result(output int lat);
    lat = 0;
    @(negedge clk);
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
      @(negedge clk);
    end
    if (!bus.out_valid) begin
      n_total++;
      $display("FAIL result_timeout: out_valid %0b required 1", bus.out_valid);
    end
  endtask

  task automatic directed(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic bin, input logic [15:0] exp_d);
    int lat;
    issue(a, b, bin);
    wait_result(lat);
    chk({name, "_lat"}, 32'(lat), 32'd2);
    chk({name, "_d"}, 32'(bus.d), 32'(exp_d));
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    logic [15:0] hold_d;
    logic        hold_b, hold_o, hold_z;

    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_d",         32'(bus.d),         32'd0);
    chk("rst_flags",     32'({bus.bout, bus.ovf, bus.zero}), 32'd0);
    @(posedge clk); #1;

    directed("wrap",     16'h0000, 16'h0001, 1'b0, 16'hFFFF);
    directed("xborrow",  16'h0100, 16'h0001, 1'b0, 16'h00FF);
    directed("sovf",     16'h8000, 16'h0001, 1'b0, 16'h7FFF);
    directed("equal",    16'h1234, 16'h1234, 1'b0, 16'h0000);
    directed("binwrap",  16'h0000, 16'hFFFF, 1'b1, 16'h0000);

    // Backpressure: result must sit still while operands wiggle at the input.
    bus.out_ready = 1'b0;
    issue(16'h4321, 16'h1111, 1'b1);
    wait_result(lat);
    hold_d = bus.d; hold_b = bus.bout; hold_o = bus.ovf; hold_z = bus.zero;
    chk("bp_d", 32'(hold_d), 32'h320F);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      bus.a = 16'($urandom); bus.b = 16'($urandom); bus.in_valid = 1'b1;
      @(negedge clk);
      if (i == 0 || i == 9) begin
        chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
      end
      chk("bp_d_stable", 32'({bus.d, bus.bout, bus.ovf, bus.zero}),
          32'({hold_d, hold_b, hold_o, hold_z}));
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_idle_in_ready",  32'(bus.in_ready),  32'd1);
    chk("bp_idle_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    directed("post_bp", 16'h0010, 16'h0020, 1'b0, 16'hFFF0);

    // Asynchronous reset between the two slices discards the operation.
    issue(16'h12FF, 16'h0001, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_d",         32'(bus.d),         32'd0);
    chk("arst_flags",     32'({bus.bout, bus.ovf, bus.zero}), 32'd0);
    chk("arst_in_ready",  32'(bus.in_ready),  32'd1);
    if (sb_q.size() > 0) void'(sb_q.pop_back());
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("arst_rel_in_ready",  32'(bus.in_ready),  32'd1);
    chk("arst_rel_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    directed("after_rst", 16'h0005, 16'h0003, 1'b0, 16'h0002);

    // Random sweep, with occasional corner operands.
    for (int i = 0; i < 2000; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 7))
        0: ra = 16'h0000;
        1: rb = 16'hFFFF;
        2: ra = 16'h8000;
        3: rb = ra;
        default: ;
      endcase
      issue(ra, rb, 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
